mb_writeback: RTL and testbench

- Parametrised successor to the reconstructed-macroblock saver in the IntraPred path.
- Accepts one reconstructed block with a valid/ready handshake. Supported sizes are 4x4, 8x8 and 16x16, selected per block.
- Streams the block row by row into an external frame-buffer write port with backpressure. It does not hold an internal frame array.
- Clamps pixels to 0..255, masks pixels that fall outside the frame, and pulses fb when the block is fully written.

---
 rtl/intra_pkg.sv | 26 ++
 rtl/mb_row_packer.sv | 38 +++
 rtl/mb_writeback.sv | 154 +++++++++++++++
 tb/tb_mb_writeback.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/intra_pkg.sv
// Shared types and helpers for the IntraPred reconstruction path.
package intra_pkg;

    typedef enum logic [1:0] {MB4, MB8, MB16, MB_RSVD} blk_mode_t;

    typedef enum logic [1:0] {IDLE, WRITE, DONE} wb_state_t;

    // Callers sign-extend their IN_W-bit pixel to 16 bits before the call.
    function automatic logic [7:0] pix_clamp8(input logic signed [15:0] v);
        if (v < 16'sd0) return 8'd0;
        if (v > 16'sd255) return 8'hFF;
        return v[7:0];
    endfunction

    function automatic logic [4:0] mode_to_edge(input logic [1:0] m);
        logic [4:0] e;
        unique case (blk_mode_t'(m))
            MB4:     e = 5'd4;
            MB8:     e = 5'd8;
            MB16:    e = 5'd16;
            default: e = 5'd0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/mb_row_packer.sv
// Selects one row of a captured block, clamps each lane to 8 bits and builds lane enables.
module mb_row_packer
    import intra_pkg::*;
#(
    parameter int unsigned MAX_MB = 16,
    parameter int unsigned IN_W   = 9,
    parameter int unsigned WIDTH  = 1280
) (
    input  logic [MAX_MB*MAX_MB*IN_W-1:0] blk_i,
    input  logic [4:0]                    row_i,
    input  logic [4:0]                    n_i,
    input  logic [15:0]                   x0_i,
    output logic [MAX_MB*8-1:0]           wdata_o,
    output logic [MAX_MB-1:0]             be_o
);

    int                     rr;
    logic                   lane_en;
    logic signed [IN_W-1:0] pix;

    always_comb begin
        wdata_o = '0;
        be_o    = '0;
        lane_en = 1'b0;
        pix     = '0;
        // Row index past the block edge only appears on the last accepted row; its data is unused.
        rr      = (int'(row_i) < int'(MAX_MB)) ? int'(row_i) : 0;
        for (int k = 0; k < int'(MAX_MB); k++) begin
            lane_en = (k < int'(n_i)) && ((32'(x0_i) + 32'(k)) < WIDTH);
            be_o[k] = lane_en;
            pix     = blk_i[(rr*int'(MAX_MB)+k)*int'(IN_W) +: IN_W];
            if (lane_en) begin
                wdata_o[k*8 +: 8] = pix_clamp8(16'(pix));
            end
        end
    end

endmodule

// File: rtl/mb_writeback.sv
// Streams one reconstructed 4x4/8x8/16x16 block row by row into a frame-buffer write port.
module mb_writeback
    import intra_pkg::*;
#(
    parameter int unsigned WIDTH  = 1280,
    parameter int unsigned LENGTH = 720,
    parameter int unsigned MAX_MB = 16,
    parameter int unsigned IN_W   = 9,
    parameter int unsigned ADDR_W = $clog2(WIDTH*LENGTH)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [31:0]                    mbnumber,
    input  logic [1:0]                     blk_mode,
    input  logic [MAX_MB*MAX_MB*IN_W-1:0]  reconst,
    output logic                           mem_we,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic [MAX_MB*8-1:0]            mem_wdata,
    output logic [MAX_MB-1:0]              mem_be,
    input  logic                           mem_ready,
    output logic                           fb,
    output logic                           err,
    output logic                           busy
);

    localparam int unsigned BlkW = MAX_MB*MAX_MB*IN_W;

    wb_state_t             state_q, state_d;
    logic [BlkW-1:0]       blk_q;
    logic [15:0]           x0_q;
    logic [4:0]            n_q, rows_q, r_q;
    logic                  we_q, fb_q, err_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [MAX_MB*8-1:0]   wdata_q;
    logic [MAX_MB-1:0]     be_q;

    logic [15:0]           y0_in, x0_in;
    logic [4:0]            n_in, rows_in;
    logic [31:0]           rem;
    logic                  bad_in, accept, last_row;
    logic [ADDR_W-1:0]     start_addr;

    logic [BlkW-1:0]       pk_blk;
    logic [4:0]            pk_row, pk_n;
    logic [15:0]           pk_x0;
    logic [MAX_MB*8-1:0]   pk_wdata;
    logic [MAX_MB-1:0]     pk_be;

    assign y0_in      = mbnumber[31:16];
    assign x0_in      = mbnumber[15:0];
    assign n_in       = mode_to_edge(blk_mode);
    assign bad_in     = (blk_mode == 2'd3) || (32'(y0_in) >= LENGTH) || (32'(x0_in) >= WIDTH);
    assign rem        = LENGTH - 32'(y0_in);
    assign rows_in    = (rem < 32'(n_in)) ? 5'(rem) : n_in;
    assign start_addr = ADDR_W'(32'(y0_in) * WIDTH + 32'(x0_in));
    assign accept     = we_q && mem_ready;
    assign last_row   = (r_q == rows_q - 5'd1);

    // In IDLE the packer looks at the live inputs so row 0 is registered on the handshake edge.
    assign pk_blk = (state_q == IDLE) ? reconst : blk_q;
    assign pk_row = (state_q == IDLE) ? 5'd0 : r_q + 5'd1;
    assign pk_n   = (state_q == IDLE) ? n_in : n_q;
    assign pk_x0  = (state_q == IDLE) ? x0_in : x0_q;

    mb_row_packer #(
        .MAX_MB (MAX_MB),
        .IN_W   (IN_W),
        .WIDTH  (WIDTH)
    ) u_packer (
        .blk_i   (pk_blk),
        .row_i   (pk_row),
        .n_i     (pk_n),
        .x0_i    (pk_x0),
        .wdata_o (pk_wdata),
        .be_o    (pk_be)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid) state_d = bad_in ? DONE : WRITE;
            WRITE:   if (accept && last_row) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            blk_q   <= '0;
            x0_q    <= '0;
            n_q     <= '0;
            rows_q  <= '0;
            r_q     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            fb_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fb_q    <= 1'b0;
            err_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        blk_q  <= reconst;
                        x0_q   <= x0_in;
                        n_q    <= n_in;
                        rows_q <= rows_in;
                        r_q    <= 5'd0;
                        if (bad_in) begin
                            fb_q  <= 1'b1;
                            err_q <= 1'b1;
                        end else begin
                            we_q    <= 1'b1;
                            addr_q  <= start_addr;
                            wdata_q <= pk_wdata;
                            be_q    <= pk_be;
                        end
                    end
                end
                WRITE: begin
                    if (accept) begin
                        if (last_row) begin
                            we_q <= 1'b0;
                            fb_q <= 1'b1;
                        end else begin
                            r_q     <= r_q + 5'd1;
                            addr_q  <= addr_q + ADDR_W'(WIDTH);
                            wdata_q <= pk_wdata;
                            be_q    <= pk_be;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;
    assign fb        = fb_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mb_writeback.sv
// Directed bench for mb_writeback; IN_W is widened to 10 so a +300 pixel is representable.
module tb_mb_writeback;

    localparam int unsigned IN_W   = 10;
    localparam int unsigned ADDR_W = 20;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           mbnumber;
    logic [1:0]            blk_mode;
    logic [16*16*IN_W-1:0] reconst;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [127:0]          mem_wdata;
    logic [15:0]           mem_be;
    logic                  mem_ready;
    logic                  fb;
    logic                  err;
    logic                  busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mb_writeback #(
        .WIDTH  (1280),
        .LENGTH (720),
        .MAX_MB (16),
        .IN_W   (IN_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mbnumber  (mbnumber),
        .blk_mode  (blk_mode),
        .reconst   (reconst),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ready (mem_ready),
        .fb        (fb),
        .err       (err),
        .busy      (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int v);
        for (int i = 0; i < 256; i++) reconst[i*IN_W +: IN_W] = 10'(v);
    endtask

    task automatic test_reset();
        checks++;
        if (in_ready !== 1'b1 || mem_we !== 1'b0 || fb !== 1'b0 || err !== 1'b0 || busy !== 1'b0
            || mem_addr !== '0 || mem_wdata !== '0 || mem_be !== '0) begin
            failures++;
            $display("FAIL reset rdy=%b we=%b fb=%b err=%b busy=%b addr=%0d be=%h exp rdy=1 rest 0",
                     in_ready, mem_we, fb, err, busy, mem_addr, mem_be);
        end
    endtask

    task automatic test_8x8();
        logic [127:0] exp_w;
        exp_w = 128'h0000_0000_0000_0000_6464_6464_6464_6464;
        fill(100);
        mbnumber = {16'd16, 16'd32}; blk_mode = 2'd1; mem_ready = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int r = 0; r < 8; r++) begin
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== 20'(20512 + r*1280)) begin
                failures++;
                $display("FAIL 8x8_addr row%0d we=%b addr=%0d exp we=1 addr=%0d",
                         r, mem_we, mem_addr, 20512 + r*1280);
            end
            checks++;
            if (mem_be !== 16'h00FF || mem_wdata !== exp_w) begin
                failures++;
                $display("FAIL 8x8_data row%0d be=%h data=%h exp be=00ff data=%h",
                         r, mem_be, mem_wdata, exp_w);
            end
            step();
        end
        checks++;
        if (fb !== 1'b1 || err !== 1'b0 || mem_we !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL 8x8_done fb=%b err=%b we=%b rdy=%b exp fb=1 err=0 we=0 rdy=0",
                     fb, err, mem_we, in_ready);
        end
        step();
        checks++;
        if (fb !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL 8x8_idle fb=%b rdy=%b busy=%b exp 0 1 0", fb, in_ready, busy);
        end
    endtask

    task automatic test_corner_clip();
        logic [127:0] exp_w;
        int writes;
        writes = 0;
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++) reconst[(i*16+j)*IN_W +: IN_W] = 10'(i*16 + j);
        mbnumber = {16'd712, 16'd1272}; blk_mode = 2'd2; mem_ready = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int r = 0; r < 8; r++) begin
            exp_w = '0;
            for (int k = 0; k < 8; k++) exp_w[k*8 +: 8] = 8'(r*16 + k);
            if (mem_we === 1'b1) writes++;
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== 20'(912632 + r*1280) || mem_be !== 16'h00FF
                || mem_wdata !== exp_w) begin
                failures++;
                $display("FAIL corner row%0d we=%b addr=%0d be=%h data=%h exp addr=%0d be=00ff data=%h",
                         r, mem_we, mem_addr, mem_be, mem_wdata, 912632 + r*1280, exp_w);
            end
            step();
        end
        checks++;
        if (fb !== 1'b1 || err !== 1'b0 || mem_we !== 1'b0 || writes != 8) begin
            failures++;
            $display("FAIL corner_done fb=%b err=%b we=%b writes=%0d exp fb=1 err=0 we=0 writes=8",
                     fb, err, mem_we, writes);
        end
        step();
    endtask

    task automatic test_stall();
        logic [31:0] exp_rows [4];
        logic [127:0] exp_w;
        int exp_r, accepted, cyc;
        exp_rows[0] = 32'h00FF_FF00;
        exp_rows[1] = 32'h0E0D_0C0B;
        exp_rows[2] = 32'h1817_1615;
        exp_rows[3] = 32'h2221_201F;
        fill(77);
        reconst[0*IN_W +: IN_W] = -10'sd5;
        reconst[1*IN_W +: IN_W] = 10'd300;
        reconst[2*IN_W +: IN_W] = 10'd255;
        reconst[3*IN_W +: IN_W] = 10'd0;
        for (int r = 1; r < 4; r++)
            for (int k = 0; k < 4; k++) reconst[(r*16+k)*IN_W +: IN_W] = 10'(r*10 + k + 1);
        mbnumber = 32'd0; blk_mode = 2'd0; mem_ready = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        exp_r = 0; accepted = 0; cyc = 0;
        while (exp_r < 4 && cyc < 40) begin
            mem_ready = ((cyc % 3) == 0);
            exp_w = {96'd0, exp_rows[exp_r]};
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== 20'(exp_r*1280) || mem_be !== 16'h000F
                || mem_wdata !== exp_w) begin
                failures++;
                $display("FAIL stall row%0d cyc%0d we=%b addr=%0d be=%h data=%h exp addr=%0d be=000f data=%h",
                         exp_r, cyc, mem_we, mem_addr, mem_be, mem_wdata, exp_r*1280, exp_w);
            end
            if (mem_ready) begin
                exp_r++;
                accepted++;
            end
            step();
            cyc++;
        end
        mem_ready = 1'b1;
        checks++;
        if (accepted != 4 || fb !== 1'b1 || err !== 1'b0 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL stall_done accepted=%0d fb=%b err=%b we=%b exp 4 1 0 0",
                     accepted, fb, err, mem_we);
        end
        step();
    endtask

    task automatic test_err();
        logic [1:0]  modes [3];
        logic [31:0] orgs  [3];
        modes[0] = 2'd3; orgs[0] = 32'd0;
        modes[1] = 2'd1; orgs[1] = {16'd720, 16'd0};
        modes[2] = 2'd0; orgs[2] = {16'd0, 16'd1280};
        fill(9);
        mem_ready = 1'b1;
        for (int t = 0; t < 3; t++) begin
            mbnumber = orgs[t]; blk_mode = modes[t]; in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            checks++;
            if (mem_we !== 1'b0 || fb !== 1'b1 || err !== 1'b1 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL err_case%0d we=%b fb=%b err=%b rdy=%b exp 0 1 1 0",
                         t, mem_we, fb, err, in_ready);
            end
            step();
            checks++;
            if (mem_we !== 1'b0 || fb !== 1'b0 || err !== 1'b0 || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL err_after%0d we=%b fb=%b err=%b rdy=%b exp 0 0 0 1",
                         t, mem_we, fb, err, in_ready);
            end
        end
    endtask

    task automatic test_reset_abort();
        fill(50);
        mbnumber = 32'd0; blk_mode = 2'd2; mem_ready = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 20'd3840) begin
            failures++;
            $display("FAIL abort_pre we=%b addr=%0d exp we=1 addr=3840", mem_we, mem_addr);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (mem_we !== 1'b0 || fb !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL abort_now we=%b fb=%b busy=%b rdy=%b exp 0 0 0 1",
                     mem_we, fb, busy, in_ready);
        end
        step();
        step();
        checks++;
        if (mem_we !== 1'b0 || fb !== 1'b0) begin
            failures++;
            $display("FAIL abort_hold we=%b fb=%b exp 0 0", mem_we, fb);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_release rdy=%b busy=%b exp 1 0", in_ready, busy);
        end
        step();
        fill(7);
        mbnumber = {16'd8, 16'd4}; blk_mode = 2'd0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int r = 0; r < 4; r++) begin
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== 20'((8 + r)*1280 + 4) || mem_be !== 16'h000F
                || mem_wdata !== 128'h0707_0707) begin
                failures++;
                $display("FAIL abort_new row%0d we=%b addr=%0d be=%h data=%h exp addr=%0d be=000f data=07070707",
                         r, mem_we, mem_addr, mem_be, mem_wdata, (8 + r)*1280 + 4);
            end
            step();
        end
        checks++;
        if (fb !== 1'b1 || err !== 1'b0) begin
            failures++;
            $display("FAIL abort_new_done fb=%b err=%b exp 1 0", fb, err);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int hs_cyc [2];
        int fb_cyc [2];
        int hs_cnt, fb_cnt, writes;
        logic hs;
        hs_cnt = 0; fb_cnt = 0; writes = 0;
        hs_cyc[0] = -1; hs_cyc[1] = -1; fb_cyc[0] = -1; fb_cyc[1] = -1;
        fill(1);
        mbnumber = 32'd0; blk_mode = 2'd1; mem_ready = 1'b1; in_valid = 1'b1;
        for (int cyc = 0; cyc < 25; cyc++) begin
            hs = in_valid && in_ready;
            if (hs && hs_cnt < 2) hs_cyc[hs_cnt] = cyc;
            if (hs) hs_cnt++;
            if (fb === 1'b1) begin
                if (fb_cnt < 2) fb_cyc[fb_cnt] = cyc;
                fb_cnt++;
            end
            if (mem_we === 1'b1 && mem_ready) writes++;
            step();
            if (hs && hs_cnt == 1) begin
                fill(2);
                mbnumber = {16'd0, 16'd16};
            end else if (hs) begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (hs_cnt != 2 || hs_cyc[0] != 0 || hs_cyc[1] != 10) begin
            failures++;
            $display("FAIL b2b_handshake count=%0d at %0d,%0d exp count=2 at 0,10",
                     hs_cnt, hs_cyc[0], hs_cyc[1]);
        end
        checks++;
        if (fb_cnt != 2 || fb_cyc[0] != 9 || fb_cyc[1] != 19 || writes != 16) begin
            failures++;
            $display("FAIL b2b_done fb_count=%0d at %0d,%0d writes=%0d exp 2 at 9,19 writes=16",
                     fb_cnt, fb_cyc[0], fb_cyc[1], writes);
        end
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        mbnumber  = '0;
        blk_mode  = '0;
        reconst   = '0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b1;
        step();
        test_8x8();
        test_corner_clip();
        test_stall();
        test_err();
        test_reset_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
